// File: rtl/dma_pkg.sv
// dma_pkg: shared encodings and byte-enable helper for the DMA write path.
// DMA_BUS_BYTES is the width of one bus word in bytes.
package dma_pkg;

  localparam int DMA_BUS_BYTES = 4;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_LOAD = 1'b1
  } state_e;

  // first: mask bytes below off; last: mask bytes above off
  function automatic logic [DMA_BUS_BYTES-1:0] gen_be(
    input logic [1:0] off,
    input logic       first,
    input logic       last
  );
    logic [DMA_BUS_BYTES-1:0] be;
    be = '1;
    if (first) be = be & (4'hF << off);
    if (last)  be = be & (4'hF >> (2'd3 - off));
    return be;
  endfunction

endpackage

// File: rtl/dmaw_wbuf_fifo.sv
// dmaw_wbuf_fifo: synchronous FIFO with flush, occupancy count and a
// combinational head that reads as zero while empty.
module dmaw_wbuf_fifo #(
  parameter int DEPTH = 32,
  parameter int AW    = 5,
  parameter int W     = 36
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic [AW:0]  count_o,
  output logic         empty_o,
  output logic         full_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign do_push = push_i & ~full_o & ~clr_i;
  assign do_pop  = pop_i & ~empty_o & ~clr_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (clr_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // storage needs no reset; the head is gated while empty
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

  assign rdata_o = empty_o ? '0 : mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/dmaw_wbuf.sv
// dmaw_wbuf: tags aligned source words with byte enables and stages them
// for the AXI write master. Define DMAW_WBUF_ERR_EN for sticky buf_err.
module dmaw_wbuf
  import dma_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_buf_clr,
  input  logic        cmd_vld,
  output logic        cmd_rdy,
  input  logic [31:0] cmd_addr,
  input  logic [15:0] cmd_len,
  input  logic        src_dvld,
  input  logic [31:0] src_data,
  output logic        src_rdy,
  output logic        dma_w_dvld,
  output logic [31:0] dma_wdata,
  output logic [3:0]  dma_wbe,
  input  logic        dma_w_dack,
  output logic [5:0]  buf_buf_word,
  output logic        cmd_done,
  output logic        buf_err
);

  localparam int BW = DMA_BUS_BYTES;
  localparam int FW = BW * 9;

  state_e        state_q, state_d;
  logic [14:0]   rem_q, rem_d;
  logic          first_q, first_d;
  logic [1:0]    aoff_q, aoff_d;
  logic [1:0]    eoff_q, eoff_d;
  logic          done_q;
  logic [16:0]   end_off;
  logic          push, pop, last;
  logic          full, empty;
  logic [BW-1:0] be;
  logic [FW-1:0] head;
  logic [AW:0]   cnt;

  assign end_off = {15'd0, cmd_addr[1:0]} + {1'b0, cmd_len};

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    first_d = first_q;
    aoff_d  = aoff_q;
    eoff_d  = eoff_q;
    cmd_rdy = 1'b0;
    src_rdy = 1'b0;
    last    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cmd_rdy = ~cfg_buf_clr;
        if (cmd_vld & ~cfg_buf_clr) begin
          rem_d   = end_off[16:2];
          first_d = 1'b1;
          aoff_d  = cmd_addr[1:0];
          eoff_d  = end_off[1:0];
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        src_rdy = ~full & ~cfg_buf_clr;
        last    = (rem_q == '0);
        if (src_dvld & src_rdy) begin
          first_d = 1'b0;
          if (last) state_d = S_IDLE;
          else      rem_d   = rem_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (cfg_buf_clr) state_d = S_IDLE;
  end

  assign push = src_dvld & src_rdy;
  assign pop  = dma_w_dack & ~cfg_buf_clr;
  assign be   = gen_be(aoff_q, first_q, 1'b0) & gen_be(eoff_q, 1'b0, last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      first_q <= 1'b0;
      aoff_q  <= '0;
      eoff_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      first_q <= first_d;
      aoff_q  <= aoff_d;
      eoff_q  <= eoff_d;
      done_q  <= push & last;
    end
  end

  dmaw_wbuf_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (FW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (cfg_buf_clr),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({be, src_data}),
    .rdata_o (head),
    .count_o (cnt),
    .empty_o (empty),
    .full_o  (full)
  );

  assign dma_w_dvld   = ~empty;
  assign dma_wbe      = head[FW-1:32];
  assign dma_wdata    = head[31:0];
  assign buf_buf_word = 6'(cnt);
  assign cmd_done     = done_q;

`ifdef DMAW_WBUF_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q
          | (dma_w_dack & empty)
          | (src_dvld & (state_q == S_IDLE));
    if (cfg_buf_clr) err_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign buf_err = err_q;
`else
  assign buf_err = 1'b0;
`endif

endmodule

// File: tb/tb_dmaw_wbuf.sv
// tb_dmaw_wbuf: directed and randomized checks of dmaw_wbuf against a
// byte-range / queue reference model.
module tb_dmaw_wbuf;

  localparam int DEPTH = 32;
`ifdef DMAW_WBUF_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_buf_clr = 1'b0;
  logic        cmd_vld = 1'b0;
  logic        cmd_rdy;
  logic [31:0] cmd_addr = '0;
  logic [15:0] cmd_len = '0;
  logic        src_dvld = 1'b0;
  logic [31:0] src_data = '0;
  logic        src_rdy;
  logic        dma_w_dvld;
  logic [31:0] dma_wdata;
  logic [3:0]  dma_wbe;
  logic        dma_w_dack = 1'b0;
  logic [5:0]  buf_buf_word;
  logic        cmd_done;
  logic        buf_err;

  dmaw_wbuf #(.DEPTH(DEPTH), .AW(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_buf_clr  (cfg_buf_clr),
    .cmd_vld      (cmd_vld),
    .cmd_rdy      (cmd_rdy),
    .cmd_addr     (cmd_addr),
    .cmd_len      (cmd_len),
    .src_dvld     (src_dvld),
    .src_data     (src_data),
    .src_rdy      (src_rdy),
    .dma_w_dvld   (dma_w_dvld),
    .dma_wdata    (dma_wdata),
    .dma_wbe      (dma_wbe),
    .dma_w_dack   (dma_w_dack),
    .buf_buf_word (buf_buf_word),
    .cmd_done     (cmd_done),
    .buf_err      (buf_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // model: FIFO contents, byte enables still to be pushed for the command
  logic [35:0] q[$];
  logic [3:0]  wbe[$];
  bit          loading = 1'b0;
  bit          exp_done = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, ".cmd_rdy"}, 64'(cmd_rdy), 64'(1));
    chk({tag, ".src_rdy"}, 64'(src_rdy), 64'(0));
    chk({tag, ".dvld"}, 64'(dma_w_dvld), 64'(0));
    chk({tag, ".wdata"}, 64'(dma_wdata), 64'(0));
    chk({tag, ".wbe"}, 64'(dma_wbe), 64'(0));
    chk({tag, ".word"}, 64'(buf_buf_word), 64'(0));
    chk({tag, ".done"}, 64'(cmd_done), 64'(0));
    chk({tag, ".err"}, 64'(buf_err), 64'(0));
  endtask

  task automatic model_clear();
    q.delete();
    wbe.delete();
    loading  = 1'b0;
    exp_done = 1'b0;
  endtask

  // byte b of word i is enabled when it lies in [off, off+len]
  task automatic issue(input logic [31:0] a, input logic [15:0] l);
    int off, lst;
    logic [3:0] be;
    cmd_vld = 1'b1; cmd_addr = a; cmd_len = l;
    src_dvld = 1'b0; dma_w_dack = 1'b0;
    #2;
    chk("cmd_rdy", 64'(cmd_rdy), 64'(!loading));
    chk("cmd_done", 64'(cmd_done), 64'(exp_done));
    @(posedge clk); #1;
    cmd_vld  = 1'b0;
    exp_done = 1'b0;
    off = int'(a[1:0]);
    lst = off + int'(l);
    wbe.delete();
    for (int i = 0; i <= lst / 4; i++) begin
      for (int b = 0; b < 4; b++)
        be[b] = ((4*i + b) >= off) && ((4*i + b) <= lst);
      wbe.push_back(be);
    end
    loading = 1'b1;
  endtask

  task automatic cycle(input bit sv, input bit ack);
    bit er, pu, po;
    logic [31:0] d;
    d = $urandom;
    src_dvld = sv; src_data = d; dma_w_dack = ack;
    #2;
    er = loading && (q.size() < DEPTH);
    chk("src_rdy", 64'(src_rdy), 64'(er));
    chk("dvld", 64'(dma_w_dvld), 64'(q.size() != 0));
    chk("count", 64'(buf_buf_word), 64'(q.size()));
    chk("cmd_done", 64'(cmd_done), 64'(exp_done));
    if (q.size() != 0) chk("head", 64'({dma_wbe, dma_wdata}), 64'(q[0]));
    pu = sv && er;
    po = ack && (q.size() != 0);
    @(posedge clk); #1;
    if (po) void'(q.pop_front());
    exp_done = 1'b0;
    if (pu) begin
      q.push_back({wbe.pop_front(), d});
      if (wbe.size() == 0) begin
        loading  = 1'b0;
        exp_done = 1'b1;
      end
    end
    src_dvld = 1'b0; dma_w_dack = 1'b0;
  endtask

  task automatic drain();
    while (q.size() != 0) cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);
  endtask

  initial begin
    int g;
    // reset state
    #12;
    chk_reset_outs("reset");
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // aligned: 4 full words, no pops
    issue(32'h1000, 16'd15);
    repeat (4) cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    chk("aligned.word", 64'(buf_buf_word), 64'(4));
    chk("aligned.wbe0", 64'(dma_wbe), 64'(4'hF));
    drain();

    // unaligned 3-word command overlapped with a single-word command
    issue(32'h1003, 16'd5);
    repeat (3) cycle(1'b1, 1'b0);
    chk("unal.wbe0", 64'(dma_wbe), 64'(4'b1000));
    issue(32'h2001, 16'd1);
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b1);
    chk("unal.wbe1", 64'(dma_wbe), 64'(4'b1111));
    cycle(1'b0, 1'b1);
    chk("unal.wbe2", 64'(dma_wbe), 64'(4'b0001));
    cycle(1'b0, 1'b1);
    chk("single.wbe", 64'(dma_wbe), 64'(4'b0110));
    drain();

    // fill to full, then stream through with the pointer wrapping
    issue(32'h3000, 16'd159);
    repeat (DEPTH) cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    chk("full.word", 64'(buf_buf_word), 64'(DEPTH));
    chk("full.src_rdy", 64'(src_rdy), 64'(0));
    g = 0;
    while (loading && g < 1000) begin cycle(1'b1, 1'b1); g++; end
    chk("full.timeout", 64'(g >= 1000), 64'(0));
    drain();

    // random overlapping commands with random handshakes
    for (int c = 0; c < 20; c++) begin
      issue($urandom, 16'($urandom_range(0, 150)));
      g = 0;
      while (loading && g < 5000) begin
        cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0));
        g++;
      end
      chk("rand.timeout", 64'(g >= 5000), 64'(0));
    end
    drain();

    // flush mid-command with 10 words buffered
    issue(32'h5002, 16'd79);
    repeat (10) cycle(1'b1, 1'b0);
    chk("flush.pre", 64'(buf_buf_word), 64'(10));
    cfg_buf_clr = 1'b1; src_dvld = 1'b1; dma_w_dack = 1'b1;
    @(posedge clk); #1;
    cfg_buf_clr = 1'b0; src_dvld = 1'b0; dma_w_dack = 1'b0;
    model_clear();
    #1;
    chk("flush.word", 64'(buf_buf_word), 64'(0));
    chk("flush.cmd_rdy", 64'(cmd_rdy), 64'(1));
    chk("flush.dvld", 64'(dma_w_dvld), 64'(0));
    chk("flush.done", 64'(cmd_done), 64'(0));
    @(posedge clk); #1;

    // empty pop: ignored, optionally flagged as sticky error
    cycle(1'b0, 1'b1);
    chk("err.set", 64'(buf_err), 64'(ERR));
    repeat (3) cycle(1'b0, 1'b0);
    chk("err.hold", 64'(buf_err), 64'(ERR));
    cfg_buf_clr = 1'b1;
    @(posedge clk); #1;
    cfg_buf_clr = 1'b0;
    #1;
    chk("err.clr", 64'(buf_err), 64'(0));
    @(posedge clk); #1;

    // asynchronous reset mid-burst
    issue(32'h4000, 16'd63);
    repeat (5) cycle(1'b1, 1'b0);
    src_dvld = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk_reset_outs("arst");
    src_dvld = 1'b0;
    model_clear();
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // largest command: 0x4001 words, remaining counter must not wrap
    issue(32'h0000_0003, 16'hFFFF);
    chk("max.nwords", 64'(wbe.size()), 64'(32'h4001));
    g = 0;
    while (loading && g < 20000) begin cycle(1'b1, 1'b1); g++; end
    chk("max.timeout", 64'(g >= 20000), 64'(0));
    cycle(1'b0, 1'b1);
    chk("max.cmd_rdy", 64'(cmd_rdy), 64'(1));
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
